check_seq_gen: RTL and testbench

//   Stimulus source for the serial ASCII pattern checker: emits a byte-per-cycle stream of

---
 rtl/check_pkg.sv | 15 +
 rtl/check_seq_gen_if.sv | 21 ++
 rtl/check_seq_gen.sv | 97 +++++++++
 tb/tb_check_seq_gen.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/check_pkg.sv
// Shared definitions for the serial ASCII "10" pattern generator, its checker and their benches.
// Holds the character constants and the sequencer state encoding.
package check_pkg;

    localparam logic [7:0] CHAR_ZERO = 8'h30;
    localparam logic [7:0] CHAR_ONE  = 8'h31;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_ONE  = 2'd1,
        SEND_ZERO = 2'd2,
        DONE      = 2'd3
    } seq_state_t;

endpackage

// File: rtl/check_seq_gen_if.sv
// Byte-per-cycle character stream with a valid/ready handshake.
// A transfer happens on a rising edge where out_valid and out_ready are both high.
interface check_seq_gen_if;

    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/check_seq_gen.sv
// Emits "10" repeated count times as ASCII characters, one per accepted transfer.
// An optional error mode turns the final '0' into a '1' to build negative cases.
module check_seq_gen
    import check_pkg::*;
#(
    parameter int         CNT_W     = 8,
    parameter logic [7:0] ONE_CHAR  = CHAR_ONE,
    parameter logic [7:0] ZERO_CHAR = CHAR_ZERO,
    parameter logic [7:0] IDLE_CHAR = CHAR_ZERO
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CNT_W-1:0]   count,
    input  logic               inject_err,
    check_seq_gen_if.master    stream,
    output logic               busy,
    output logic               done
);

    seq_state_t       state;
    logic [CNT_W-1:0] remaining;
    logic             err_q;
    logic             last_pair;
    logic [7:0]       zero_slot_char;

    // The second character of the final pair is the one the error mode corrupts.
    assign last_pair      = (remaining == CNT_W'(1));
    assign zero_slot_char = (last_pair && err_q) ? ONE_CHAR : ZERO_CHAR;

    // NOTE: every register here, outputs included, uses non-blocking assignments and is
    // cleared by the asynchronous reset, so no partial character survives a mid-sequence reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            remaining        <= '0;
            err_q            <= 1'b0;
            stream.out_valid <= 1'b0;
            stream.out_data  <= IDLE_CHAR;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start && (count != '0)) begin
                        state            <= SEND_ONE;
                        remaining        <= count;
                        err_q            <= inject_err;
                        stream.out_valid <= 1'b1;
                        stream.out_data  <= ONE_CHAR;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                    end else if (start) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end

                SEND_ONE: begin
                    if (stream.out_ready) begin
                        state           <= SEND_ZERO;
                        stream.out_data <= zero_slot_char;
                    end
                end

                SEND_ZERO: begin
                    if (stream.out_ready) begin
                        if (last_pair) begin
                            // remaining stays at 1 here; it is only ever decremented above 1.
                            state            <= DONE;
                            stream.out_valid <= 1'b0;
                            stream.out_data  <= IDLE_CHAR;
                            busy             <= 1'b0;
                            done             <= 1'b1;
                        end else begin
                            state           <= SEND_ONE;
                            remaining       <= remaining - 1'b1;
                            stream.out_data <= ONE_CHAR;
                        end
                    end
                end

                default: begin
                    state            <= IDLE;
                    stream.out_valid <= 1'b0;
                    stream.out_data  <= IDLE_CHAR;
                    busy             <= 1'b0;
                    done             <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_check_seq_gen.sv
// Scoreboard bench for check_seq_gen: stimulus pushes the expected character stream,
// an independent monitor pops and compares on every accepted transfer.
module tb_check_seq_gen;
    import check_pkg::*;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] count = '0;
    logic             inject_err = 1'b0;
    logic             busy;
    logic             done;

    check_seq_gen_if sif ();

    check_seq_gen #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .count      (count),
        .inject_err (inject_err),
        .stream     (sif),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ch;
        bit         last;
    } exp_t;

    exp_t sb_q[$];
    int   checks     = 0;
    int   errors     = 0;
    int   xfer_cnt   = 0;
    int   done_cnt   = 0;
    bit   zero_req   = 1'b0;
    int   ready_mode = 0;
    int   ready_phase = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Sink back-pressure: always ready, the 1,0,0 repeating pattern, or random.
    initial begin
        sif.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (ready_mode)
                1: begin
                    sif.out_ready = ((ready_phase % 3) == 0);
                    ready_phase++;
                end
                2:       sif.out_ready = 1'($urandom);
                default: sif.out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: samples mid-cycle what the next rising edge will transfer.
    initial begin
        bit         exp_done = 1'b0;
        bit         prev_stall = 1'b0;
        logic [7:0] prev_data = '0;
        exp_t       it;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                exp_done   = 1'b0;
                prev_stall = 1'b0;
            end else begin
                check("done_pulse", 32'(done), 32'(exp_done));
                check("busy_vs_valid", 32'(busy), 32'(sif.out_valid));
                if (!sif.out_valid)
                    check("idle_char", 32'(sif.out_data), 32'(8'h30));
                if (prev_stall) begin
                    check("stall_valid_hold", 32'(sif.out_valid), 32'(1));
                    check("stall_data_hold", 32'(sif.out_data), 32'(prev_data));
                end
                if (done) done_cnt++;
                exp_done = zero_req;
                zero_req = 1'b0;
                if (sif.out_valid && sif.out_ready) begin
                    xfer_cnt++;
                    if (sb_q.size() == 0) begin
                        fail_now("unexpected_char");
                    end else begin
                        it = sb_q.pop_front();
                        check("stream_char", 32'(sif.out_data), 32'(it.ch));
                        if (it.last) exp_done = 1'b1;
                    end
                end
                prev_stall = sif.out_valid && !sif.out_ready;
                prev_data  = sif.out_data;
            end
        end
    end

    task automatic push_expected(input int cnt, input bit err);
        exp_t e;
        for (int i = 0; i < cnt; i++) begin
            e.ch   = CHAR_ONE;
            e.last = 1'b0;
            sb_q.push_back(e);
            e.ch   = (err && (i == cnt - 1)) ? CHAR_ONE : CHAR_ZERO;
            e.last = (i == cnt - 1);
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int waited = 0;
        @(negedge clk);
        while (busy && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        if (busy) fail_now("idle_timeout");
    endtask

    task automatic run_seq(input int cnt, input bit err);
        int base;
        int budget;
        int waited;
        wait_idle();
        base       = done_cnt;
        start      = 1'b1;
        count      = CNT_W'(cnt);
        inject_err = err;
        push_expected(cnt, err);
        if (cnt == 0) zero_req = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        count      = CNT_W'($urandom);
        inject_err = 1'($urandom);
        if (cnt != 0)
            check("first_char_latency", {23'd0, sif.out_valid, sif.out_data}, {23'd0, 1'b1, CHAR_ONE});
        else
            check("zero_count_no_valid", 32'(sif.out_valid), 32'(0));
        budget = 16 * cnt + 40;
        waited = 0;
        // Junk start pulses while busy must be ignored.
        while (done_cnt == base && waited < budget) begin
            start = busy && (($urandom % 4) == 0);
            count = CNT_W'($urandom);
            inject_err = 1'($urandom);
            @(negedge clk);
            waited++;
        end
        start = 1'b0;
        if (done_cnt == base) fail_now("done_timeout");
    endtask

    initial begin
        int base_x;
        int waited;
        repeat (3) @(negedge clk);
        check("reset_valid", 32'(sif.out_valid), 32'(0));
        check("reset_data", 32'(sif.out_data), 32'(8'h30));
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_seq(2, 1'b0);
        run_seq(1, 1'b0);
        run_seq(3, 1'b1);
        ready_mode  = 1;
        ready_phase = 0;
        run_seq(3, 1'b0);
        ready_mode = 0;
        run_seq(0, 1'b0);
        run_seq((1 << CNT_W) - 1, 1'b0);
        run_seq(1, 1'b1);

        for (int n = 0; n < 25; n++) begin
            ready_mode = int'($urandom % 3);
            run_seq(int'($urandom_range(0, 10)), 1'($urandom));
        end

        // Mid-sequence reset after the third character of a count=4 sequence.
        ready_mode = 0;
        wait_idle();
        start      = 1'b1;
        count      = CNT_W'(4);
        inject_err = 1'b0;
        push_expected(4, 1'b0);
        base_x = xfer_cnt;
        @(negedge clk);
        waited = 0;
        while (xfer_cnt < base_x + 3 && waited < 50) begin
            start = busy;
            count = CNT_W'(2);
            @(negedge clk);
            waited++;
        end
        start = 1'b0;
        if (xfer_cnt < base_x + 3) fail_now("reset_setup_timeout");
        rst_n = 1'b0;
        #1;
        check("midreset_valid", 32'(sif.out_valid), 32'(0));
        check("midreset_busy", 32'(busy), 32'(0));
        check("midreset_done", 32'(done), 32'(0));
        check("midreset_data", 32'(sif.out_data), 32'(8'h30));
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base_x = xfer_cnt;
        run_seq(2, 1'b0);
        check("post_reset_xfers", 32'(xfer_cnt - base_x), 32'(4));

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "simulation did not complete");
    end

endmodule
